// File: rtl/serial_pattern_tx.sv
// Serial pattern transmitter: captures a parallel pattern and shifts it out MSB-first,
// one bit per DIV clocks, with back-to-back repeat and immediate abort.
//
// state | meaning
// IDLE  | waiting for start; outputs quiet
// SEND  | shifting the captured frame out on x
// DONE  | one-clock completion pulse on done
module serial_pattern_tx #(
  parameter int WIDTH = 48,
  parameter int CNT_W = 6,
  parameter int DIV   = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] pattern,
  input  logic [CNT_W-1:0] len,
  input  logic             repeat_en,
  input  logic             abort,
  output logic             x,
  output logic             x_valid,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] bit_index
);

  localparam int               DIV_W    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [CNT_W-1:0] WIDTH_C  = CNT_W'(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    SEND = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] cap, cap_nxt;
  logic [CNT_W-1:0] frame_len, frame_len_nxt;
  logic [CNT_W-1:0] idx, idx_nxt;
  logic [DIV_W-1:0] div_cnt, div_nxt;

  logic             x_nxt, x_valid_nxt, busy_nxt, done_nxt;
  logic [CNT_W-1:0] bit_index_nxt;

  logic [CNT_W-1:0] eff_len;
  logic             go, bit_end, frame_end;

  // A zero or oversize length means a full-width frame.
  assign eff_len   = (len == '0 || len > WIDTH_C) ? WIDTH_C : len;
  assign go        = (state == IDLE) && start && !abort;
  assign bit_end   = (div_cnt == '0);
  assign frame_end = (state == SEND) && bit_end && (idx == '0);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      cap       <= '0;
      frame_len <= '0;
      idx       <= '0;
      div_cnt   <= '0;
      x         <= 1'b0;
      x_valid   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      bit_index <= '0;
    end else begin
      state     <= state_nxt;
      cap       <= cap_nxt;
      frame_len <= frame_len_nxt;
      idx       <= idx_nxt;
      div_cnt   <= div_nxt;
      x         <= x_nxt;
      x_valid   <= x_valid_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
      bit_index <= bit_index_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (go) state_nxt = SEND;
      SEND: begin
        if (abort)                       state_nxt = IDLE;
        else if (frame_end && !repeat_en) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath next values plus the registered-output decode of the next state.
  always_comb begin
    cap_nxt       = cap;
    frame_len_nxt = frame_len;
    idx_nxt       = idx;
    div_nxt       = div_cnt;
    if (go) begin
      cap_nxt       = pattern;
      frame_len_nxt = eff_len;
      idx_nxt       = eff_len - CNT_W'(1);
      div_nxt       = DIV_LAST;
    end else if (state == SEND && !abort) begin
      if (bit_end) begin
        div_nxt = DIV_LAST;
        if (idx == '0) idx_nxt = frame_len - CNT_W'(1);
        else           idx_nxt = idx - CNT_W'(1);
      end else begin
        div_nxt = div_cnt - DIV_W'(1);
      end
    end

    x_valid_nxt   = (state_nxt == SEND);
    busy_nxt      = (state_nxt == SEND);
    done_nxt      = (state_nxt == DONE);
    x_nxt         = x_valid_nxt ? cap_nxt[idx_nxt] : 1'b0;
    bit_index_nxt = x_valid_nxt ? idx_nxt : '0;
  end

endmodule
